tcdm_pipe_unit: RTL and testbench



---
 rtl/tcdm_pipe_pkg.sv | 32 +++
 rtl/tcdm_pipe_reg.sv | 33 +++
 rtl/tcdm_pipe_unit.sv | 162 ++++++++++++++++
 tb/tb_tcdm_pipe_unit.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_pipe_pkg.sv
// Shared types and limits for the per-bank TCDM pipeline unit.
// Payload field widths here define the default bank geometry used by tcdm_pipe_unit.
package tcdm_pipe_pkg;

    localparam int unsigned TCDM_ADDR_WIDTH = 12;
    localparam int unsigned TCDM_DATA_WIDTH = 32;
    localparam int unsigned TCDM_BE_WIDTH   = TCDM_DATA_WIDTH / 8;
    localparam int unsigned TCDM_ID_WIDTH   = 4;

    // Deepest configuration (both stages enabled) keeps at most this many requests outstanding.
    localparam int unsigned MAX_INFLIGHT = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_APPLY = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic [TCDM_ADDR_WIDTH-1:0] add;
        logic                       wen;
        logic [TCDM_DATA_WIDTH-1:0] wdata;
        logic [TCDM_BE_WIDTH-1:0]   be;
        logic [TCDM_ID_WIDTH-1:0]   id;
    } req_payload_t;

    typedef struct packed {
        logic [TCDM_DATA_WIDTH-1:0] rdata;
        logic [TCDM_ID_WIDTH-1:0]   id;
    } resp_payload_t;

endpackage

// File: rtl/tcdm_pipe_reg.sv
// Valid + payload pipeline register that can be bypassed at runtime.
// The register keeps sampling while bypassed, so it is empty whenever the input has been idle.
module tcdm_pipe_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_bypass,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = i_bypass ? i_valid : r_valid;
    assign o_data  = i_bypass ? i_data  : r_data;

endmodule

// File: rtl/tcdm_pipe_unit.sv
// Per-bank TCDM pipeline unit: optional request and response registers between the
// interconnect and one SRAM bank, reconfigured only after all in-flight accesses drain.
//
// state    | meaning
// ST_RUN   | normal operation, grant follows request
// ST_DRAIN | grants blocked, waiting for outstanding responses
// ST_APPLY | new stage selection latched, cfg_ready_o pulsed
module tcdm_pipe_unit
    import tcdm_pipe_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = TCDM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = TCDM_DATA_WIDTH,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH   = TCDM_ID_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  slv_req_i,
    input  logic [ADDR_WIDTH-1:0] slv_add_i,
    input  logic                  slv_wen_i,
    input  logic [DATA_WIDTH-1:0] slv_wdata_i,
    input  logic [BE_WIDTH-1:0]   slv_be_i,
    input  logic [ID_WIDTH-1:0]   slv_id_i,
    output logic                  slv_gnt_o,
    output logic                  slv_r_valid_o,
    output logic [DATA_WIDTH-1:0] slv_r_rdata_o,
    output logic [ID_WIDTH-1:0]   slv_r_id_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_add_o,
    output logic                  mem_wen_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [BE_WIDTH-1:0]   mem_be_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  cfg_pipe_req_i,
    input  logic                  cfg_pipe_resp_i,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    output logic                  pipe_req_q_o,
    output logic                  pipe_resp_q_o
);

    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

    pipe_state_e         r_state;
    pipe_state_e         w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_pipe_req;
    logic                r_pipe_resp;
    logic                r_acc_valid;
    logic [ID_WIDTH-1:0] r_acc_id;

    logic                w_gnt;
    logic                w_accept;
    logic                w_mem_valid;
    logic                w_resp_valid;
    req_payload_t        w_req_pl;
    req_payload_t        w_mem_pl;
    resp_payload_t       w_acc_pl;
    resp_payload_t       w_resp_pl;

    // A pending configuration request wins over a request arriving in the same cycle.
    assign w_gnt    = (r_state == ST_RUN) && slv_req_i && !cfg_valid_i;
    assign w_accept = slv_req_i && w_gnt;

    assign w_req_pl = '{
        add:   slv_add_i,
        wen:   slv_wen_i,
        wdata: slv_wdata_i,
        be:    slv_be_i,
        id:    slv_id_i
    };

    tcdm_pipe_reg #(
        .WIDTH ($bits(req_payload_t))
    ) u_req_reg (
        .clk      (clk),
        .rst      (rst),
        .i_bypass (!r_pipe_req),
        .i_valid  (w_accept),
        .i_data   (w_req_pl),
        .o_valid  (w_mem_valid),
        .o_data   (w_mem_pl)
    );

    assign mem_req_o   = w_mem_valid;
    assign mem_add_o   = w_mem_pl.add;
    assign mem_wen_o   = w_mem_pl.wen;
    assign mem_wdata_o = w_mem_pl.wdata;
    assign mem_be_o    = w_mem_pl.be;

    // The bank returns data one cycle after the access; the ID waits alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_valid <= 1'b0;
            r_acc_id    <= '0;
        end else begin
            r_acc_valid <= w_mem_valid;
            if (w_mem_valid) begin
                r_acc_id <= w_mem_pl.id;
            end
        end
    end

    assign w_acc_pl = '{rdata: mem_rdata_i, id: r_acc_id};

    tcdm_pipe_reg #(
        .WIDTH ($bits(resp_payload_t))
    ) u_resp_reg (
        .clk      (clk),
        .rst      (rst),
        .i_bypass (!r_pipe_resp),
        .i_valid  (r_acc_valid),
        .i_data   (w_acc_pl),
        .o_valid  (w_resp_valid),
        .o_data   (w_resp_pl)
    );

    assign slv_gnt_o     = w_gnt;
    assign slv_r_valid_o = w_resp_valid;
    assign slv_r_rdata_o = w_resp_pl.rdata;
    assign slv_r_id_o    = w_resp_pl.id;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept && !w_resp_valid) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (!w_accept && w_resp_valid) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (cfg_valid_i)  w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_cnt == '0)  w_state_nxt = ST_APPLY;
            ST_APPLY: w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    // Stage selection is sampled in the APPLY cycle itself, even if cfg_valid_i has dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_pipe_req  <= 1'b0;
            r_pipe_resp <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_APPLY) begin
                r_pipe_req  <= cfg_pipe_req_i;
                r_pipe_resp <= cfg_pipe_resp_i;
            end
        end
    end

    assign cfg_ready_o   = (r_state == ST_APPLY);
    assign pipe_req_q_o  = r_pipe_req;
    assign pipe_resp_q_o = r_pipe_resp;

endmodule

// File: tb/tb_tcdm_pipe_unit.sv
// Scoreboard bench for tcdm_pipe_unit: a behavioural SRAM answers accesses, expected
// responses (cycle, id, data) are queued at accept time and compared on slv_r_valid_o.
module tb_tcdm_pipe_unit;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          slv_req_i = 1'b0;
    logic [AW-1:0] slv_add_i = '0;
    logic          slv_wen_i = 1'b1;
    logic [DW-1:0] slv_wdata_i = '0;
    logic [BW-1:0] slv_be_i = '0;
    logic [IW-1:0] slv_id_i = '0;
    logic          slv_gnt_o;
    logic          slv_r_valid_o;
    logic [DW-1:0] slv_r_rdata_o;
    logic [IW-1:0] slv_r_id_o;
    logic          mem_req_o;
    logic [AW-1:0] mem_add_o;
    logic          mem_wen_o;
    logic [DW-1:0] mem_wdata_o;
    logic [BW-1:0] mem_be_o;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          cfg_pipe_req_i = 1'b0;
    logic          cfg_pipe_resp_i = 1'b0;
    logic          cfg_valid_i = 1'b0;
    logic          cfg_ready_o;
    logic          pipe_req_q_o;
    logic          pipe_resp_q_o;

    tcdm_pipe_unit #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BE_WIDTH   (BW),
        .ID_WIDTH   (IW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .slv_req_i       (slv_req_i),
        .slv_add_i       (slv_add_i),
        .slv_wen_i       (slv_wen_i),
        .slv_wdata_i     (slv_wdata_i),
        .slv_be_i        (slv_be_i),
        .slv_id_i        (slv_id_i),
        .slv_gnt_o       (slv_gnt_o),
        .slv_r_valid_o   (slv_r_valid_o),
        .slv_r_rdata_o   (slv_r_rdata_o),
        .slv_r_id_o      (slv_r_id_o),
        .mem_req_o       (mem_req_o),
        .mem_add_o       (mem_add_o),
        .mem_wen_o       (mem_wen_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_be_o        (mem_be_o),
        .mem_rdata_i     (mem_rdata_i),
        .cfg_pipe_req_i  (cfg_pipe_req_i),
        .cfg_pipe_resp_i (cfg_pipe_resp_i),
        .cfg_valid_i     (cfg_valid_i),
        .cfg_ready_o     (cfg_ready_o),
        .pipe_req_q_o    (pipe_req_q_o),
        .pipe_resp_q_o   (pipe_resp_q_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned   cyc;
        logic [IW-1:0] id;
        logic          rd;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          sb_q[$];
    int unsigned   cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    logic [DW-1:0] tbmem [0:(1<<AW)-1];
    logic          tb_pr = 1'b0;
    logic          tb_ps = 1'b0;

    function automatic logic [DW-1:0] golden(input logic [AW-1:0] a);
        if (a == 12'h010) return 32'hDEADBEEF;
        return {4'hC, a, 4'h5, ~a};
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) tbmem[i] = golden(i[AW-1:0]);
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM: read data appears one cycle after the access.
    always @(posedge clk) begin
        if (mem_req_o === 1'b1) begin
            if (mem_wen_o) begin
                mem_rdata_i <= tbmem[mem_add_o];
            end else begin
                for (int b = 0; b < BW; b++)
                    if (mem_be_o[b]) tbmem[mem_add_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (slv_r_valid_o) begin
                if (sb_q.size() == 0) begin
                    check_val("unexpected_resp", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_val("resp_cycle", cyc, e.cyc);
                    check_val("resp_id", slv_r_id_o, e.id);
                    if (e.rd) check_val("resp_rdata", slv_r_rdata_o, e.rdata);
                end
            end
            if (slv_req_i && slv_gnt_o) begin
                exp_t n;
                n.cyc   = cyc + 1 + int'(tb_pr) + int'(tb_ps);
                n.id    = slv_id_i;
                n.rd    = slv_wen_i;
                n.rdata = golden(slv_add_i);
                sb_q.push_back(n);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [AW-1:0] a, input logic wen, input logic [DW-1:0] wd,
                             input logic [IW-1:0] id);
        slv_req_i   = 1'b1;
        slv_add_i   = a;
        slv_wen_i   = wen;
        slv_wdata_i = wd;
        slv_be_i    = '1;
        slv_id_i    = id;
    endtask

    task automatic drive_idle();
        slv_req_i = 1'b0;
        slv_wen_i = 1'b1;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (sb_q.size() != 0 && k < 30) begin
            step();
            k++;
        end
        check_val("drain_timeout", sb_q.size(), 0);
        repeat (2) step();
    endtask

    // Raises cfg_valid_i in the current cycle; n_cyc = cycles from rise to cfg_ready_o.
    task automatic cfg_change(input logic pr, input logic ps, output int unsigned n_cyc);
        int unsigned k = 0;
        bit          done = 0;
        cfg_pipe_req_i  = pr;
        cfg_pipe_resp_i = ps;
        cfg_valid_i     = 1'b1;
        while (!done && k < 20) begin
            #3;
            if (k == 0 && slv_req_i) check_val("gnt_blocked_by_cfg", slv_gnt_o, 0);
            if (cfg_ready_o) begin
                done        = 1;
                cfg_valid_i = 1'b0;
                tb_pr       = pr;
                tb_ps       = ps;
                check_val("drained_at_ready", sb_q.size(), 0);
            end else begin
                @(posedge clk);
                #1;
                drive_idle();
                k++;
            end
        end
        if (!done) begin
            check_val("cfg_ready_timeout", 0, 1);
            cfg_valid_i = 1'b0;
        end
        n_cyc = k;
        step();
        check_val("pipe_req_q", pipe_req_q_o, pr);
        check_val("pipe_resp_q", pipe_resp_q_o, ps);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #3;
        check_val("rst_r_valid", slv_r_valid_o, 0);
        check_val("rst_mem_req", mem_req_o, 0);
        check_val("rst_cfg_ready", cfg_ready_o, 0);
        check_val("rst_pipe_req", pipe_req_q_o, 0);
        check_val("rst_pipe_resp", pipe_resp_q_o, 0);
        step();

        // Bypass: memory access in the accept cycle, response one cycle later.
        drive_req(12'h010, 1'b1, '0, 4'd3);
        #3;
        check_val("byp_gnt", slv_gnt_o, 1);
        check_val("byp_mem_req", mem_req_o, 1);
        check_val("byp_mem_add", mem_add_o, 12'h010);
        check_val("byp_mem_wen", mem_wen_o, 1);
        step();
        drive_idle();
        wait_drain();

        // Both stages, idle reconfiguration, then four back-to-back reads.
        cfg_change(1'b1, 1'b1, n);
        check_val("idle_cfg_cycles", n, 2);
        for (int i = 0; i < 4; i++) begin
            drive_req(12'h020 + 12'(i), 1'b1, '0, 4'(i + 1));
            #3;
            check_val("b2b_gnt", slv_gnt_o, 1);
            check_val("b2b_mem_req", mem_req_o, (i > 0) ? 1 : 0);
            if (i > 0) check_val("b2b_mem_add", mem_add_o, 12'h020 + 12'(i - 1));
            step();
        end
        drive_idle();
        #3;
        check_val("b2b_mem_req_last", mem_req_o, 1);
        check_val("b2b_mem_add_last", mem_add_o, 12'h023);
        step();
        #3;
        check_val("b2b_mem_req_off", mem_req_o, 0);
        wait_drain();

        // Request stage only: access one cycle late, response at +2.
        cfg_change(1'b1, 1'b0, n);
        drive_req(12'h800, 1'b0, 32'h1234_5678, 4'd5);
        #3;
        check_val("c10_mem_req_T", mem_req_o, 0);
        step();
        drive_idle();
        #3;
        check_val("c10_mem_req_T1", mem_req_o, 1);
        check_val("c10_mem_wen", mem_wen_o, 0);
        check_val("c10_mem_wdata", mem_wdata_o, 32'h1234_5678);
        step();
        wait_drain();

        // Response stage only: access in the accept cycle, response at +2.
        cfg_change(1'b0, 1'b1, n);
        drive_req(12'h801, 1'b0, 32'hCAFE_F00D, 4'd5);
        #3;
        check_val("c01_mem_req_T", mem_req_o, 1);
        check_val("c01_mem_add", mem_add_o, 12'h801);
        step();
        drive_idle();
        wait_drain();

        // Reconfigure 11 -> 00 with three reads outstanding and a colliding request.
        cfg_change(1'b1, 1'b1, n);
        for (int i = 0; i < 3; i++) begin
            drive_req(12'h030 + 12'(i), 1'b1, '0, 4'(6 + i));
            step();
        end
        drive_req(12'h0F0, 1'b1, '0, 4'd9);
        cfg_change(1'b0, 1'b0, n);
        check_val("busy_cfg_cycles", n, 4);
        drive_req(12'h040, 1'b1, '0, 4'd10);
        #3;
        check_val("post_apply_gnt", slv_gnt_o, 1);
        check_val("post_apply_mem_req", mem_req_o, 1);
        step();
        drive_idle();
        wait_drain();

        // Reset with two reads in flight under 11: responses are dropped.
        cfg_change(1'b1, 1'b1, n);
        check_val("idle_cfg_cycles_2", n, 2);
        drive_req(12'h050, 1'b1, '0, 4'd11);
        step();
        drive_req(12'h051, 1'b1, '0, 4'd12);
        step();
        drive_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb_q.delete();
        tb_pr = 1'b0;
        tb_ps = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #3;
            check_val("no_resp_after_rst", slv_r_valid_o, 0);
            step();
        end
        check_val("rst_mid_pipe_req", pipe_req_q_o, 0);
        check_val("rst_mid_pipe_resp", pipe_resp_q_o, 0);
        cfg_change(1'b0, 1'b0, n);
        check_val("post_rst_cfg_cycles", n, 2);
        drive_req(12'h0AB, 1'b1, '0, 4'd1);
        step();
        drive_idle();
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
